dbg_prog_loader: RTL

Byte-stream-driven program loader that owns the SoC debug memory port and the CPU reset hold. It accepts framed commands on a valid/ready byte stream (fed by UART RX or a bench). It sets the load address, writes and reads back words through dbg_mem_op/dbg_wren/dbg_adr/dbg_do/dbg_di, and halts or releases the CPU. It replaces the bench-only force sequence with synthesizable logic sitting between the UART and the crv32 memory mux.

---
 rtl/dbg_loader_pkg.sv | 31 +++
 rtl/dbg_byte_shifter.sv | 59 +++++
 rtl/dbg_prog_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dbg_loader_pkg.sv
// Shared definitions for the debug program loader: opcodes, FSM states and
// the layout of the STATUS response byte.
package dbg_loader_pkg;

  localparam logic [7:0] OP_SETADR = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_RUN    = 8'h04;
  localparam logic [7:0] OP_HALT   = 8'h05;
  localparam logic [7:0] OP_STATUS = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_EXEC,
    ST_MEM,
    ST_TX
  } state_e;

  localparam int STAT_RUN_BIT = 0;
  localparam int STAT_ERR_BIT = 1;

  function automatic logic [7:0] status_byte(input logic err, input logic run);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_ERR_BIT] = err;
    s[STAT_RUN_BIT] = run;
    return s;
  endfunction

endpackage

// File: rtl/dbg_byte_shifter.sv
// Little-endian byte assembler/disassembler: push inserts a byte at the
// current count, load takes a parallel word, shift emits bytes LSB first.
module dbg_byte_shifter #(
  parameter int NBYTES = 4,
  parameter int CW     = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [NBYTES*8-1:0]   load_data,
  input  logic                  push,
  input  logic [7:0]            push_byte,
  input  logic                  shift,
  input  logic [CW-1:0]         last_idx,
  output logic [NBYTES*8-1:0]   word_ins,
  output logic [7:0]            out_byte,
  output logic                  done
);

  logic [NBYTES*8-1:0] word_q, word_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // word_ins lets the owner see the complete word in the same cycle the last byte arrives
  always_comb begin
    word_ins = word_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_q == CW'(i)) word_ins[i*8 +: 8] = push_byte;
    end
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load) begin
      word_d = load_data;
      cnt_d  = '0;
    end else if (push) begin
      word_d = word_ins;
      cnt_d  = cnt_q + CW'(1);
    end else if (shift) begin
      word_d = word_q >> 8;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_byte = word_q[7:0];
  assign done     = (cnt_q == last_idx);

endmodule

// File: rtl/dbg_prog_loader.sv
// Byte-command program loader: owns the debug memory port and the CPU reset
// hold, driven by a valid/ready command stream with a byte response stream.
module dbg_prog_loader import dbg_loader_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BOOT_HALT   = 1,
  parameter int ACK_TIMEOUT = 255,
  parameter int WE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              cpu_n_reset,
  output logic              dbg_mem_op,
  output logic [WE_W-1:0]   dbg_wren,
  output logic [ADDR_W-1:0] dbg_adr,
  output logic [DATA_W-1:0] dbg_do,
  input  logic [DATA_W-1:0] dbg_di,
  input  logic              dbg_ack,
  output logic              err
);

  localparam int AB       = ADDR_W / 8;
  localparam int SH_BYTES = (AB > WE_W) ? AB : WE_W;
  localparam int SH_W     = SH_BYTES * 8;
  localparam int CW       = $clog2(SH_BYTES + 1);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                run_q, run_d;
  logic                err_q, err_d;
  logic                mem_op_q, mem_op_d;
  logic [WE_W-1:0]     wren_q, wren_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   do_q, do_d;
  logic [15:0]         tmo_q, tmo_d;
  logic [CW-1:0]       last_q, last_d;

  logic                sh_load, sh_push, sh_shift, sh_done;
  logic [SH_W-1:0]     sh_load_data, sh_ins;
  logic [7:0]          sh_byte;

  dbg_byte_shifter #(.NBYTES(SH_BYTES), .CW(CW)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_load_data),
    .push      (sh_push),
    .push_byte (in_data),
    .shift     (sh_shift),
    .last_idx  (last_q),
    .word_ins  (sh_ins),
    .out_byte  (sh_byte),
    .done      (sh_done)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    run_d        = run_q;
    err_d        = err_q;
    mem_op_d     = mem_op_q;
    wren_d       = wren_q;
    adr_d        = adr_q;
    do_d         = do_q;
    tmo_d        = '0;
    last_d       = last_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_push      = 1'b0;
    sh_shift     = 1'b0;
    in_ready     = (state_q == ST_IDLE) || (state_q == ST_ARG);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = in_data;
          case (in_data)
            OP_SETADR: begin
              sh_load = 1'b1;
              last_d  = CW'(AB - 1);
              state_d = ST_ARG;
            end
            OP_WRITE: begin
              sh_load = 1'b1;
              last_d  = CW'(WE_W - 1);
              state_d = ST_ARG;
            end
            OP_READ: begin
              if (run_q) begin
                err_d = 1'b1;
              end else begin
                mem_op_d = 1'b1;
                wren_d   = '0;
                adr_d    = addr_q;
                do_d     = '0;
                state_d  = ST_MEM;
              end
            end
            OP_RUN:  run_d = 1'b1;
            OP_HALT: begin
              run_d = 1'b0;
              err_d = 1'b0;
            end
            OP_STATUS: begin
              sh_load      = 1'b1;
              sh_load_data = SH_W'(status_byte(err_q, run_q));
              last_d       = '0;
              state_d      = ST_TX;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_ARG: begin
        if (in_valid) begin
          sh_push = 1'b1;
          if (sh_done) begin
            state_d = ST_EXEC;
            if (op_q == OP_SETADR) begin
              addr_d = sh_ins[ADDR_W-1:0];
            end else if (run_q) begin
              err_d = 1'b1;
            end else begin
              mem_op_d = 1'b1;
              wren_d   = '1;
              adr_d    = addr_q;
              do_d     = sh_ins[DATA_W-1:0];
              state_d  = ST_MEM;
            end
          end
        end
      end

      ST_EXEC: state_d = ST_IDLE;

      // An aborted op still completes a READ so the host always gets WE_W bytes
      ST_MEM: begin
        if (dbg_ack || (tmo_q == TMO_LAST)) begin
          mem_op_d = 1'b0;
          wren_d   = '0;
          do_d     = '0;
          if (dbg_ack) addr_d = addr_q + ADDR_W'(WE_W);
          else         err_d  = 1'b1;
          if (op_q == OP_READ) begin
            sh_load      = 1'b1;
            sh_load_data = dbg_ack ? SH_W'(dbg_di) : '0;
            last_d       = CW'(WE_W - 1);
            state_d      = ST_TX;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_TX: begin
        if (out_ready) begin
          if (sh_done) state_d  = ST_IDLE;
          else         sh_shift = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      run_q    <= (BOOT_HALT == 0);
      err_q    <= 1'b0;
      mem_op_q <= 1'b0;
      wren_q   <= '0;
      adr_q    <= '0;
      do_q     <= '0;
      tmo_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      run_q    <= run_d;
      err_q    <= err_d;
      mem_op_q <= mem_op_d;
      wren_q   <= wren_d;
      adr_q    <= adr_d;
      do_q     <= do_d;
      tmo_q    <= tmo_d;
      last_q   <= last_d;
    end
  end

  assign out_valid   = (state_q == ST_TX);
  assign out_data    = out_valid ? sh_byte : 8'h00;
  assign cpu_n_reset = run_q;
  assign dbg_mem_op  = mem_op_q;
  assign dbg_wren    = wren_q;
  assign dbg_adr     = adr_q;
  assign dbg_do      = do_q;
  assign err         = err_q;

endmodule
